// File: rtl/kmap_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// kmap_sweep_ctrl
//
// Purpose:
//   Synthesizable self-check engine for a combinational N_IN-input function
//   block. On start it walks x through every input vector, samples the
//   function output once per vector, builds the captured truth table and
//   counts how many minterms differ from a latched expected mask.
//
// Parameters:
//   N_IN   - width of the function input vector (sweep covers 2^N_IN vectors)
//   SETTLE - extra wait cycles per vector before sampling (0..15)
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   begin a sweep (only looked at in IDLE)
//   abort        in   synchronous cancel of a running sweep
//   expected     in   expected minterm mask, bit i = expected out for x=i
//   f_in         in   output of the function block under test
//   x            out  vector driven to the function block, indexed [N_IN:1]
//   busy         out  high while a sweep is running or completing
//   done         out  one-cycle pulse at sweep completion
//   truth        out  captured truth table, bit i = f_in sampled for x=i
//   pass         out  truth == expected, valid from done onward
//   mismatch_cnt out  number of differing minterms
//
// Optional feature (macro KMAP_SWEEP_FIRSTERR_EN):
//   first_err    out  index of the first mismatching vector of the sweep
//   err_seen     out  a mismatch has been seen in the current sweep
// ---------------------------------------------------------------------------
module kmap_sweep_ctrl #(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [(1<<N_IN)-1:0]   expected,
    input  logic                   f_in,
    output logic [N_IN:1]          x,
    output logic                   busy,
    output logic                   done,
    output logic [(1<<N_IN)-1:0]   truth,
    output logic                   pass,
    output logic [N_IN:0]          mismatch_cnt
`ifdef KMAP_SWEEP_FIRSTERR_EN
    ,
    output logic [N_IN-1:0]        first_err,
    output logic                   err_seen
`endif
);

    localparam int unsigned    NV       = 1 << N_IN;
    localparam logic [3:0]     SETTLE_C = SETTLE[3:0];
    // idx is one bit wider than needed so the terminal compare never wraps
    localparam logic [N_IN:0]  LAST_IDX = (N_IN+1)'(NV - 1);
    localparam logic [N_IN:0]  ONE      = (N_IN+1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t              state;
    logic [N_IN:0]       idx;
    logic [3:0]          cnt;
    logic [NV-1:0]       exp_latched;

    logic [N_IN-1:0]     idx_lo;
    logic [N_IN:0]       idx_next;
    logic                miss;

    assign idx_lo   = idx[N_IN-1:0];
    assign idx_next = idx + ONE;
    assign miss     = f_in ^ exp_latched[idx_lo];

    // Single sequencer: all outputs are registered here, so f_in only ever
    // reaches outputs through a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            cnt          <= '0;
            exp_latched  <= '0;
            x            <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            truth        <= '0;
            pass         <= 1'b0;
            mismatch_cnt <= '0;
`ifdef KMAP_SWEEP_FIRSTERR_EN
            first_err    <= '0;
            err_seen     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // busy stays high through the done cycle and drops here,
                    // unless start immediately re-arms a new sweep
                    busy <= 1'b0;
                    if (start) begin
                        state        <= RUN;
                        busy         <= 1'b1;
                        idx          <= '0;
                        cnt          <= '0;
                        x            <= '0;
                        exp_latched  <= expected;
                        truth        <= '0;
                        mismatch_cnt <= '0;
                        pass         <= 1'b0;
`ifdef KMAP_SWEEP_FIRSTERR_EN
                        first_err    <= '0;
                        err_seen     <= 1'b0;
`endif
                    end
                end

                RUN: begin
                    if (abort) begin
                        // abort wins over a same-cycle sample; partial
                        // truth and mismatch count are left as they are
                        state <= IDLE;
                        busy  <= 1'b0;
                        pass  <= 1'b0;
                    end else if (cnt != SETTLE_C) begin
                        cnt <= cnt + 4'd1;
                    end else begin
                        truth[idx_lo] <= f_in;
                        if (miss) begin
                            mismatch_cnt <= mismatch_cnt + ONE;
                        end
`ifdef KMAP_SWEEP_FIRSTERR_EN
                        if (miss && !err_seen) begin
                            first_err <= idx_lo;
                            err_seen  <= 1'b1;
                        end
`endif
                        cnt <= '0;
                        if (idx == LAST_IDX) begin
                            state <= DONE;
                        end else begin
                            idx <= idx_next;
                            x   <= idx_next[N_IN-1:0];
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b1;
                    pass  <= (mismatch_cnt == '0);
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kmap_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_kmap_sweep_ctrl
//
// Scoreboard bench for kmap_sweep_ctrl. The function block is modelled as a
// 16-entry lookup of fmask. Each accepted sweep pushes its expected result
// (truth table, mismatch count, pass, completion cycle) into a queue; a
// monitor pops and compares on every done pulse. A second instance with
// SETTLE=0 covers the single-cycle-per-vector case.
// ---------------------------------------------------------------------------
module tb_kmap_sweep_ctrl;

    localparam int N_IN   = 4;
    localparam int SETTLE = 1;
    localparam int LAT    = 16 * (SETTLE + 1) + 1;
    localparam int LAT0   = 16 * (0 + 1) + 1;

    typedef struct {
        logic [15:0] truth;
        logic [4:0]  mism;
        logic        pass;
        int          done_cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] expected;
    logic [15:0] fmask;
    logic        f_in;
    logic [4:1]  x;
    logic        busy;
    logic        done;
    logic [15:0] truth;
    logic        pass;
    logic [4:0]  mismatch_cnt;

    logic        start0;
    logic        abort0;
    logic        f_in0;
    logic [4:1]  x0;
    logic        busy0;
    logic        done0;
    logic [15:0] truth0;
    logic        pass0;
    logic [4:0]  mismatch_cnt0;

    int   cyc;
    int   checks;
    int   errors;
    exp_t sb_q[$];
    exp_t mon_e;

    // Combinational function block under test: out = fmask[x]
    assign f_in  = fmask[x];
    assign f_in0 = fmask[x0];

    kmap_sweep_ctrl #(.N_IN(N_IN), .SETTLE(SETTLE)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .expected     (expected),
        .f_in         (f_in),
        .x            (x),
        .busy         (busy),
        .done         (done),
        .truth        (truth),
        .pass         (pass),
        .mismatch_cnt (mismatch_cnt)
    );

    kmap_sweep_ctrl #(.N_IN(N_IN), .SETTLE(0)) u_dut0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start0),
        .abort        (abort0),
        .expected     (expected),
        .f_in         (f_in0),
        .x            (x0),
        .busy         (busy0),
        .done         (done0),
        .truth        (truth0),
        .pass         (pass0),
        .mismatch_cnt (mismatch_cnt0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference result of a complete sweep: the truth table is the function
    // itself, mismatches are the differing minterms.
    function automatic exp_t model_sweep(input logic [15:0] fm, input logic [15:0] ex);
        exp_t r;
        r.truth    = fm;
        r.mism     = 5'($countones(fm ^ ex));
        r.pass     = (fm == ex);
        r.done_cyc = 0;
        return r;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while ((busy || done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wait_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_x(input logic [3:0] v);
        int n = 0;
        while (x !== v && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reach_x", {28'd0, x}, {28'd0, v});
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic applyStimulus(input logic [15:0] fm, input logic [15:0] ex,
                                 input bit push_it, output int acc);
        exp_t e;
        wait_idle();
        fmask    = fm;
        expected = ex;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc   = cyc;
        if (push_it) begin
            e          = model_sweep(fm, ex);
            e.done_cyc = acc + LAT;
            sb_q.push_back(e);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding sweep
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done actual=1 expected=0 cyc=%0d", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                checkOutput("truth",      {16'd0, truth},        {16'd0, mon_e.truth});
                checkOutput("mismatch",   {27'd0, mismatch_cnt}, {27'd0, mon_e.mism});
                checkOutput("pass",       {31'd0, pass},         {31'd0, mon_e.pass});
                checkOutput("done_cycle", cyc,                   mon_e.done_cyc);
                checkOutput("busy_done",  {31'd0, busy},         32'd1);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          acc;
        int          acc2;
        int          n;
        logic [15:0] fm;
        logic [15:0] ex;
        exp_t        e;

        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        start0   = 1'b0;
        abort0   = 1'b0;
        expected = '0;
        fmask    = '0;
        repeat (3) @(negedge clk);

        // Reset state
        checkOutput("rst_x",     {28'd0, x},            32'd0);
        checkOutput("rst_busy",  {31'd0, busy},         32'd0);
        checkOutput("rst_done",  {31'd0, done},         32'd0);
        checkOutput("rst_truth", {16'd0, truth},        32'd0);
        checkOutput("rst_pass",  {31'd0, pass},         32'd0);
        checkOutput("rst_mism",  {27'd0, mismatch_cnt}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Matching function
        applyStimulus(16'hA5C3, 16'hA5C3, 1'b1, acc);
        wait_drain();
        checkOutput("hold_x_15", {28'd0, x}, 32'd15);

        // Two mismatching minterms (bits 1 and 15)
        applyStimulus(16'hA5C3, 16'h25C1, 1'b1, acc);
        wait_drain();

        // Randomized functions with a few flipped expected bits
        for (int i = 0; i < 6; i++) begin
            fm = 16'($urandom);
            ex = fm;
            n  = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) begin
                ex[$urandom_range(0, 15)] ^= 1'b1;
            end
            applyStimulus(fm, ex, 1'b1, acc);
            wait_drain();
        end

        // Abort while x=5 is being sampled: that sample is discarded
        applyStimulus(16'hFFFF, 16'h0000, 1'b0, acc);
        wait_x(4'd5);
        repeat (SETTLE) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_busy",  {31'd0, busy},         32'd0);
        checkOutput("abort_truth", {16'd0, truth},        32'h001F);
        checkOutput("abort_mism",  {27'd0, mismatch_cnt}, 32'd5);
        checkOutput("abort_pass",  {31'd0, pass},         32'd0);
        repeat (40) @(negedge clk);
        checkOutput("abort_hold",  {16'd0, truth},        32'h001F);
        applyStimulus(16'h3C96, 16'h3C96, 1'b1, acc);
        wait_drain();

        // Start pulsed while busy must not restart or queue a sweep
        applyStimulus(16'h0F0F, 16'h0F0E, 1'b1, acc);
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (40) @(negedge clk);

        // Back-to-back with start held high
        wait_idle();
        fmask    = 16'h8001;
        expected = 16'h8001;
        start    = 1'b1;
        @(negedge clk);
        acc        = cyc;
        e          = model_sweep(16'h8001, 16'h8001);
        e.done_cyc = acc + LAT;
        sb_q.push_back(e);
        e.done_cyc = acc + LAT + 1 + LAT;
        sb_q.push_back(e);
        repeat (LAT + 1) @(negedge clk);
        start = 1'b0;
        checkOutput("rearm_x",    {28'd0, x},    32'd0);
        checkOutput("rearm_busy", {31'd0, busy}, 32'd1);
        wait_drain();

        // Reset mid-sweep at vector 7
        applyStimulus(16'h5A5A, 16'h5A5A, 1'b0, acc);
        wait_x(4'd7);
        rst_n = 1'b0;
        #1;
        checkOutput("mrst_x",     {28'd0, x},            32'd0);
        checkOutput("mrst_busy",  {31'd0, busy},         32'd0);
        checkOutput("mrst_done",  {31'd0, done},         32'd0);
        checkOutput("mrst_truth", {16'd0, truth},        32'd0);
        checkOutput("mrst_pass",  {31'd0, pass},         32'd0);
        checkOutput("mrst_mism",  {27'd0, mismatch_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        applyStimulus(16'hC3A5, 16'hC3A4, 1'b1, acc);
        wait_drain();

        // SETTLE=0 instance: one cycle per vector
        fmask    = 16'h1234;
        expected = 16'h1234;
        start0   = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        acc    = cyc;
        n      = 0;
        while (!done0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        acc2 = cyc;
        checkOutput("s0_done",    {31'd0, done0},         32'd1);
        checkOutput("s0_latency", acc2 - acc,             LAT0);
        checkOutput("s0_truth",   {16'd0, truth0},        32'h1234);
        checkOutput("s0_pass",    {31'd0, pass0},         32'd1);
        checkOutput("s0_mism",    {27'd0, mismatch_cnt0}, 32'd0);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
